// File: rtl/mux_lectura_registro_pkg.sv
// Shared definitions for the matrix-multiplier register bank (read and write sides).
// Holds the byte address map, register counts, status bit positions and the
// read FSM / source-select enumerations.
package mux_lectura_registro_pkg;

  // Byte address map (9-bit bus)
  localparam logic [8:0] OPERAND_BASE = 9'h000;
  localparam logic [8:0] RESULT_BASE  = 9'h100;
  localparam logic [8:0] ADDR_START   = 9'h180;
  localparam logic [8:0] ADDR_STATUS  = 9'h184;

  localparam int OPERAND_COUNT = 64;
  localparam int RESULT_COUNT  = 16;

  // Status register layout
  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    RESPOND
  } state_t;

  // Which source feeds the read data register
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_OPERAND,
    SRC_RESULT,
    SRC_STATUS
  } src_t;

endpackage

// File: rtl/mux_lectura_registro_decodificador_lectura.sv
// decodificador_lectura: combinational read-address decoder.
// Ports: addr (byte address) -> sel (source), idx (register index), err (unmapped/misaligned).
// No state; the caller registers the result.
module decodificador_lectura
  import mux_lectura_registro_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output src_t                  sel,
  output logic [5:0]            idx,
  output logic                  err
);

  always_comb begin
    sel = SRC_ZERO;
    idx = '0;
    err = 1'b0;
    if (addr[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (addr[8] == OPERAND_BASE[8]) begin
      // Lower half of the map: 64 operand words
      sel = SRC_OPERAND;
      idx = addr[7:2];
    end else if (addr[7:6] == RESULT_BASE[7:6]) begin
      // 0x100..0x13C: 16 result words
      sel = SRC_RESULT;
      idx = {2'b00, addr[5:2]};
    end else if (addr == ADDR_START) begin
      // Start is write-only: reads return zero without error
      sel = SRC_ZERO;
    end else if (addr == ADDR_STATUS) begin
      sel = SRC_STATUS;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/mux_lectura_registro.sv
// mux_lectura_registro: read responder for the 4x4 matrix-multiplier register bank.
// Ports: Address/Read request in, ReadData/ReadValid/ReadError response out (held until
// ReadAck), OperandData/ResultData/Busy/Done sources, DoneFlag sticky status.
module mux_lectura_registro
  import mux_lectura_registro_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic [ADDR_WIDTH-1:0]               Address,
  input  logic                                Read,
  input  logic                                ReadAck,
  input  logic [OPERAND_COUNT*DATA_WIDTH-1:0] OperandData,
  input  logic [RESULT_COUNT*DATA_WIDTH-1:0]  ResultData,
  input  logic                                Busy,
  input  logic                                Done,
  output logic [DATA_WIDTH-1:0]               ReadData,
  output logic                                ReadValid,
  output logic                                ReadError,
  output logic                                DoneFlag
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  src_t                    dec_sel;
  logic [5:0]              dec_idx;
  logic                    dec_err;
  logic [DATA_WIDTH-1:0]   rd_next;

  decodificador_lectura #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .addr (addr_q),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .err  (dec_err)
  );

  always_comb begin
    rd_next = '0;
    case (dec_sel)
      SRC_OPERAND: rd_next = OperandData[int'(dec_idx)*DATA_WIDTH +: DATA_WIDTH];
      SRC_RESULT:  rd_next = ResultData[int'(dec_idx[3:0])*DATA_WIDTH +: DATA_WIDTH];
      SRC_STATUS: begin
        rd_next[BUSY_BIT] = Busy;
        rd_next[DONE_BIT] = DoneFlag;
      end
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      ReadData  <= '0;
      ReadValid <= 1'b0;
      ReadError <= 1'b0;
      DoneFlag  <= 1'b0;
    end else begin
      // Set beats clear so a completion arriving as status is acked is not lost
      if (Done) begin
        DoneFlag <= 1'b1;
      end else if (state == RESPOND && ReadAck && addr_q == ADDR_STATUS) begin
        DoneFlag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (Read) begin
            addr_q <= Address;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Snapshot: data and error are frozen here for the whole response
          ReadData  <= rd_next;
          ReadError <= dec_err;
          ReadValid <= 1'b1;
          state     <= RESPOND;
        end
        RESPOND: begin
          if (ReadAck) begin
            ReadValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ReadValid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_lectura_registro.sv
// Self-checking bench for mux_lectura_registro: scoreboard of expected responses
// pushed at request time, popped when ReadValid rises.
module tb_mux_lectura_registro;

  logic              Clock;
  logic              Reset;
  logic [8:0]        Address;
  logic              Read;
  logic              ReadAck;
  logic [64*32-1:0]  OperandData;
  logic [16*32-1:0]  ResultData;
  logic              Busy;
  logic              Done;
  logic [31:0]       ReadData;
  logic              ReadValid;
  logic              ReadError;
  logic              DoneFlag;

  mux_lectura_registro #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (9)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Address     (Address),
    .Read        (Read),
    .ReadAck     (ReadAck),
    .OperandData (OperandData),
    .ResultData  (ResultData),
    .Busy        (Busy),
    .Done        (Done),
    .ReadData    (ReadData),
    .ReadValid   (ReadValid),
    .ReadError   (ReadError),
    .DoneFlag    (DoneFlag)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [31:0] ops [64];
  logic [31:0] res [16];
  logic [32:0] exp_q [$];   // {error, data}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pack_sources();
    for (int k = 0; k < 64; k++) OperandData[k*32 +: 32] = ops[k];
    for (int j = 0; j < 16; j++) ResultData[j*32 +: 32] = res[j];
  endtask

  task automatic pulse_done();
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  // One full read transaction; hold = cycles with ack low after valid,
  // mutate = scramble sources during the hold, done_at_ack = Done on the ack edge.
  task automatic do_read(input logic [8:0] a, input logic [31:0] ed, input logic ee,
                         input int hold, input bit mutate, input bit done_at_ack);
    int waited;
    logic [32:0] e;
    exp_q.push_back({ee, ed});
    Address = a;
    Read    = 1'b1;
    tick();
    Read = 1'b0;
    check_val("valid_in_capture", {31'b0, ReadValid}, 32'd0);
    waited = 1;
    while (!ReadValid && waited < 10) begin
      tick();
      waited++;
    end
    check_val("latency", waited, 32'd2);
    if (ReadValid) begin
      e = exp_q.pop_front();
      check_val("data", ReadData, e[31:0]);
      check_val("error", {31'b0, ReadError}, {31'b0, e[32]});
      for (int h = 0; h < hold; h++) begin
        if (mutate) begin
          for (int k = 0; k < 64; k++) ops[k] = $urandom;
          for (int j = 0; j < 16; j++) res[j] = $urandom;
          pack_sources();
        end
        tick();
        check_val("hold_valid", {31'b0, ReadValid}, 32'd1);
        check_val("hold_data", ReadData, e[31:0]);
      end
      ReadAck = 1'b1;
      Done    = done_at_ack;
      tick();
      ReadAck = 1'b0;
      Done    = 1'b0;
      check_val("valid_after_ack", {31'b0, ReadValid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] e;
    for (int k = 0; k < 64; k++) ops[k] = 32'hA000_0000 + k;
    for (int j = 0; j < 16; j++) res[j] = 32'hB000_0000 + j;
    ops[1]  = 32'hDEAD_BEEF;
    res[15] = 32'h1234_5678;
    pack_sources();
    Reset = 1'b1; Address = '0; Read = 1'b0; ReadAck = 1'b0; Busy = 1'b0; Done = 1'b0;
    tick();
    tick();
    check_val("rst_data", ReadData, 32'd0);
    check_val("rst_valid", {31'b0, ReadValid}, 32'd0);
    check_val("rst_error", {31'b0, ReadError}, 32'd0);
    check_val("rst_doneflag", {31'b0, DoneFlag}, 32'd0);
    Reset = 1'b0;
    tick();

    // Operand read, held five cycles
    do_read(9'h004, 32'hDEAD_BEEF, 1'b0, 5, 1'b0, 1'b0);
    // Result read with sources changing during the response
    do_read(9'h13C, 32'h1234_5678, 1'b0, 3, 1'b1, 1'b0);
    do_read(9'h0FC, ops[63], 1'b0, 0, 1'b0, 1'b0);
    do_read(9'h100, res[0], 1'b0, 0, 1'b0, 1'b0);

    // Sticky done flag, cleared by status read
    pulse_done();
    check_val("doneflag_set", {31'b0, DoneFlag}, 32'd1);
    do_read(9'h184, 32'h2, 1'b0, 1, 1'b0, 1'b0);
    check_val("doneflag_cleared", {31'b0, DoneFlag}, 32'd0);
    do_read(9'h184, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    Busy = 1'b1;
    do_read(9'h184, 32'h1, 1'b0, 0, 1'b0, 1'b0);
    Busy = 1'b0;

    // Done on the same edge as the status ack: set wins
    pulse_done();
    do_read(9'h184, 32'h2, 1'b0, 0, 1'b0, 1'b1);
    check_val("doneflag_set_wins", {31'b0, DoneFlag}, 32'd1);
    do_read(9'h184, 32'h2, 1'b0, 0, 1'b0, 1'b0);
    check_val("doneflag_clear2", {31'b0, DoneFlag}, 32'd0);

    // Unmapped / misaligned / write-only
    do_read(9'h002, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    do_read(9'h140, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    do_read(9'h1FC, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    do_read(9'h180, 32'h0, 1'b0, 0, 1'b0, 1'b0);

    // Second Read during CAPTURE is ignored
    exp_q.push_back({1'b0, ops[2]});
    Address = 9'h008; Read = 1'b1;
    tick();
    Address = 9'h00C;
    tick();
    Read = 1'b0;
    check_val("dbl_valid", {31'b0, ReadValid}, 32'd1);
    e = exp_q.pop_front();
    check_val("dbl_data", ReadData, e[31:0]);
    ReadAck = 1'b1;
    tick();
    ReadAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("dbl_no_second", {31'b0, ReadValid}, 32'd0);
    end

    // Reset during RESPOND drops the transaction
    pulse_done();
    exp_q.push_back({1'b0, ops[4]});
    Address = 9'h010; Read = 1'b1;
    tick();
    Read = 1'b0;
    tick();
    check_val("prerst_valid", {31'b0, ReadValid}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    void'(exp_q.pop_front());
    check_val("midrst_data", ReadData, 32'd0);
    check_val("midrst_valid", {31'b0, ReadValid}, 32'd0);
    check_val("midrst_error", {31'b0, ReadError}, 32'd0);
    check_val("midrst_doneflag", {31'b0, DoneFlag}, 32'd0);
    do_read(9'h000, ops[0], 1'b0, 1, 1'b0, 1'b0);

    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
